riscv_if_axil_fetch: RTL and testbench
======================================

RISCV_IF_AXIL_FETCH -- requirements
Module: riscv_if_axil_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: width of fetch PC and AXI-Lite read address.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: AXI-Lite read data width; only 32 and 64 are legal.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  input  1  new-fetch acceptance enable.
REQ-006 SHALL have port i_read_instr  input  1  fetch request strobe from the program counter.
REQ-007 SHALL have port i_pc  input  ADDR_WIDTH  byte address of the requested instruction.
REQ-008 SHALL have port i_flush  input  1  kill any in-flight fetch.
REQ-009 SHALL have port o_instr  output  32  fetched instruction word.
REQ-010 SHALL have port o_instr_valid  output  1  one-cycle pulse: o_instr, o_instr_pc and o_fetch_err are valid.
REQ-011 SHALL have port o_instr_pc  output  ADDR_WIDTH  PC of the instruction delivered.
REQ-012 SHALL have port o_fetch_err  output  1  bus error or misaligned fetch, qualified by o_instr_valid.
REQ-013 SHALL have port o_busy  output  1  fetch in progress; requests are not accepted.
REQ-014 SHALL have ports m_axil_araddr (output, ADDR_WIDTH), m_axil_arprot (output, 3), m_axil_arvalid (output, 1), m_axil_arready (input, 1): AXI-Lite read address channel.
REQ-015 SHALL have ports m_axil_rdata (input, DATA_WIDTH), m_axil_rresp (input, 2), m_axil_rvalid (input, 1), m_axil_rready (output, 1): AXI-Lite read data channel.

Function
REQ-016 SHALL implement a state machine with states IDLE, ADDR, DATA and ERR.
REQ-017 IDLE: on enable=1, i_read_instr=1, i_flush=0 with i_pc[1:0]=0, SHALL latch i_pc and move to ADDR; m_axil_arvalid rises the next cycle.
REQ-018 IDLE: an accepted request with i_pc[1:0]!=0 SHALL move to ERR and issue no bus transaction.
REQ-019 ADDR: SHALL hold m_axil_arvalid=1 and drive m_axil_araddr = latched PC with the low log2(DATA_WIDTH/8) bits cleared, stable until arready; on arvalid&&arready SHALL move to DATA.
REQ-020 m_axil_arprot SHALL be constant 3'b100 (instruction, secure, unprivileged).
REQ-021 DATA: SHALL hold m_axil_rready=1; on rvalid SHALL register the response, pulse o_instr_valid for the next cycle and return to IDLE.
REQ-022 Word select: for DATA_WIDTH=64, o_instr = rdata[63:32] if PC bit 2 is 1, else rdata[31:0]; for DATA_WIDTH=32, o_instr = rdata.
REQ-023 o_fetch_err SHALL be rresp[1] (SLVERR/DECERR) on bus responses and 1 for ERR; in ERR, o_instr SHALL be 0.
REQ-024 ERR: SHALL pulse o_instr_valid with o_fetch_err=1 one cycle after acceptance, then return to IDLE.
REQ-025 o_instr_pc SHALL equal the unmodified latched PC of the delivered fetch.
REQ-026 o_busy SHALL be 1 in ADDR, DATA and ERR, and 0 in IDLE; i_read_instr while busy SHALL be ignored.
REQ-027 Latency with zero-wait slave: request at cycle N, arvalid at N+1, rvalid at N+2, o_instr_valid at N+3.
REQ-028 i_flush in ADDR or DATA SHALL set a kill flag; arvalid SHALL NOT be withdrawn, and the transaction SHALL complete on the bus with its response consumed and no o_instr_valid.
REQ-029 i_flush in ERR SHALL suppress the error pulse; i_flush in IDLE SHALL block acceptance that cycle.
REQ-030 The kill flag SHALL clear on return to IDLE.
REQ-031 enable=0 SHALL block only new acceptance; an in-flight fetch SHALL complete normally.
REQ-032 At most one outstanding AXI read SHALL exist at any time.
REQ-033 The next request SHALL be acceptable in the cycle after the o_instr_valid pulse.

Reset
REQ-034 nreset=0 SHALL asynchronously force IDLE, clear the kill flag and drive o_instr=0, o_instr_valid=0, o_instr_pc=0, o_fetch_err=0, o_busy=0, m_axil_arvalid=0, m_axil_araddr=0 and m_axil_rready=0.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no output pulse after release; slave-side recovery is out of scope.

Verification
REQ-036 DATA_WIDTH=64, zero-wait slave, request pc=0x1004, rdata=0xAAAA_BBBB_1111_2222, rresp=0 -> araddr=0x1000, o_instr=0xAAAABBBB, o_instr_pc=0x1004, o_fetch_err=0, valid at N+3.
REQ-037 arready delayed 3 cycles -> arvalid held and araddr stable throughout; exactly one o_instr_valid pulse.
REQ-038 rresp=2'b10 -> o_instr_valid=1 with o_fetch_err=1.
REQ-039 Request pc=0x1002 -> no arvalid; o_instr_valid with o_fetch_err=1 one cycle after acceptance.
REQ-040 i_flush asserted while in DATA -> rready still completes the handshake; no o_instr_valid; a new request two cycles later succeeds.
REQ-041 nreset asserted while in ADDR -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/riscv_if_axil_fetch.sv
`default_nettype none
// ============================================================================
// Module   : riscv_if_axil_fetch
// Brief    : Single-outstanding instruction fetch unit that reads aligned
//            words over an AXI-Lite read channel and delivers one 32-bit
//            instruction per request, with flush and misalignment handling.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_if_axil_fetch #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic                  i_read_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_flush,
    output logic [31:0]           o_instr,
    output logic                  o_instr_valid,
    output logic [ADDR_WIDTH-1:0] o_instr_pc,
    output logic                  o_fetch_err,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    // Byte-offset bits stripped from the bus address (2 for 32-bit, 3 for 64-bit)
    localparam int c_OFF = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MASK = {{(ADDR_WIDTH - c_OFF){1'b1}}, {c_OFF{1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_kill;
    logic [31:0]           r_instr;
    logic                  r_valid;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [31:0]           w_word;
    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_drop;
    logic                  w_unused_rresp0;

    assign w_accept        = (r_state == c_IDLE) && enable && i_read_instr && !i_flush;
    assign w_misaligned    = |i_pc[1:0];
    assign w_ar_hs         = (r_state == c_ADDR) && m_axil_arready;
    assign w_r_hs          = (r_state == c_DATA) && m_axil_rvalid;
    // A flush arriving in the same cycle as the response still kills it
    assign w_drop          = r_kill || i_flush;
    // Only the error bit of the response matters; OKAY vs EXOKAY is irrelevant
    assign w_unused_rresp0 = m_axil_rresp[0];

    // Pick the 32-bit instruction out of the bus beat
    generate
        if (DATA_WIDTH == 64) begin : g_sel64
            assign w_word = r_pc[2] ? m_axil_rdata[DATA_WIDTH-1:32] : m_axil_rdata[31:0];
        end else begin : g_sel32
            assign w_word = m_axil_rdata[31:0];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_next = w_misaligned ? c_ERR : c_ADDR;
            c_ADDR: if (m_axil_arready) w_next = c_DATA;
            c_DATA: if (m_axil_rvalid) w_next = c_IDLE;
            c_ERR:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Bus handshake and busy outputs decoded from the current state
    always_comb begin
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        o_busy         = 1'b0;
        case (r_state)
            c_ADDR: begin
                m_axil_arvalid = 1'b1;
                o_busy         = 1'b1;
            end
            c_DATA: begin
                m_axil_rready  = 1'b1;
                o_busy         = 1'b1;
            end
            c_ERR:  o_busy     = 1'b1;
            default: ;
        endcase
    end

    // Request capture and kill flag
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pc     <= '0;
            r_araddr <= '0;
            r_kill   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pc     <= i_pc;
                r_araddr <= i_pc & c_ADDR_MASK;
            end
            if (w_next == c_IDLE) begin
                r_kill <= 1'b0;
            end else if (((r_state == c_ADDR) || (r_state == c_DATA)) && i_flush) begin
                r_kill <= 1'b1;
            end
        end
    end

    // Registered delivery of the fetched instruction or the misalignment error
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_instr_pc <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_r_hs) begin
                if (!w_drop) begin
                    r_valid    <= 1'b1;
                    r_instr    <= w_word;
                    r_err      <= m_axil_rresp[1];
                    r_instr_pc <= r_pc;
                end
            end else if ((r_state == c_ERR) && !i_flush) begin
                r_valid    <= 1'b1;
                r_instr    <= '0;
                r_err      <= 1'b1;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_fetch_err   = r_err;
    assign o_instr_pc    = r_instr_pc;
    assign m_axil_araddr = r_araddr;
    assign m_axil_arprot = 3'b100;

    // w_ar_hs documents the address handshake; the FSM uses arready directly in ADDR
    logic w_unused_ar_hs;
    assign w_unused_ar_hs = w_ar_hs;

endmodule
`default_nettype wire

// File: tb/tb_riscv_if_axil_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_if_axil_fetch
// Brief    : Randomized bench for riscv_if_axil_fetch with a bus-slave model,
//            a word-addressed memory model and a scoreboard of expected fetches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_if_axil_fetch;

    logic        clk;
    logic        nreset;
    logic        enable;
    logic        i_read_instr;
    logic [63:0] i_pc;
    logic        i_flush;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [63:0] o_instr_pc;
    logic        o_fetch_err;
    logic        o_busy;
    logic [63:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [63:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;

    riscv_if_axil_fetch #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .enable         (enable),
        .i_read_instr   (i_read_instr),
        .i_pc           (i_pc),
        .i_flush        (i_flush),
        .o_instr        (o_instr),
        .o_instr_valid  (o_instr_valid),
        .o_instr_pc     (o_instr_pc),
        .o_fetch_err    (o_fetch_err),
        .o_busy         (o_busy),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mem[logic [63:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          last_valid_cyc = -1;
    int          pushes = 0;
    int          pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every delivered instruction must match the oldest expected fetch
    always @(negedge clk) begin
        if (nreset && o_instr_valid) begin
            exp_t e;
            pulses++;
            last_valid_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid pc=%h (t=%0t)", o_instr_pc, $time);
            end else begin
                e = sb_q.pop_front();
                chk("instr", {32'd0, o_instr}, {32'd0, e.instr});
                chk("instr_pc", o_instr_pc, e.pc);
                chk("fetch_err", {63'd0, o_fetch_err}, {63'd0, e.err});
            end
        end
    end

    // fmode: 0 none, 1 flush while address pending, 2 flush while data pending, 3 flush in error
    task automatic do_fetch(input logic [63:0] pc, input int ard, input int rd,
                            input logic [1:0] resp, input int fmode);
        logic [63:0] ad;
        logic [63:0] word;
        exp_t        e;
        bit          mis;
        bit          killed;
        mis = (pc[1:0] != 2'b00);
        ad  = {pc[63:3], 3'b000};
        if (!mem.exists(ad)) mem[ad] = {$urandom, $urandom};
        word = mem[ad];
        killed = (fmode == 1 && ard > 0 && !mis) || (fmode == 2 && rd > 0 && !mis) ||
                 (fmode == 3 && mis);
        if (!killed) begin
            e.pc    = pc;
            e.err   = mis ? 1'b1 : resp[1];
            e.instr = mis ? 32'd0 : (pc[2] ? word[63:32] : word[31:0]);
            sb_q.push_back(e);
            pushes++;
        end
        @(posedge clk); #1;
        i_read_instr = 1'b1; i_pc = pc; enable = 1'b1; req_cyc = cyc;
        @(posedge clk); #1;
        i_read_instr = 1'b0; enable = 1'($urandom_range(0, 1));
        if (mis) begin
            if (fmode == 3) i_flush = 1'b1;
            @(negedge clk);
            chk("err_no_arvalid", {63'd0, m_axil_arvalid}, 64'd0);
            chk("err_busy", {63'd0, o_busy}, 64'd1);
            @(posedge clk); #1;
            i_flush = 1'b0;
            repeat (2) begin
                @(negedge clk);
                chk("err_idle_arvalid", {63'd0, m_axil_arvalid}, 64'd0);
            end
        end else begin
            for (int i = 0; i < ard; i++) begin
                if (fmode == 1 && i == 0) i_flush = 1'b1;
                @(negedge clk);
                chk("ar_wait_arvalid", {63'd0, m_axil_arvalid}, 64'd1);
                chk("ar_wait_araddr", m_axil_araddr, ad);
                chk("ar_wait_busy", {63'd0, o_busy}, 64'd1);
                @(posedge clk); #1;
                i_flush = 1'b0;
            end
            m_axil_arready = 1'b1;
            @(negedge clk);
            chk("arvalid", {63'd0, m_axil_arvalid}, 64'd1);
            chk("araddr", m_axil_araddr, ad);
            chk("arprot", {61'd0, m_axil_arprot}, 64'd4);
            @(posedge clk); #1;
            m_axil_arready = 1'b0;
            for (int i = 0; i < rd; i++) begin
                if (fmode == 2 && i == 0) i_flush = 1'b1;
                @(negedge clk);
                chk("r_wait_rready", {63'd0, m_axil_rready}, 64'd1);
                chk("r_wait_no_arvalid", {63'd0, m_axil_arvalid}, 64'd0);
                @(posedge clk); #1;
                i_flush = 1'b0;
            end
            m_axil_rvalid = 1'b1; m_axil_rdata = word; m_axil_rresp = resp;
            @(negedge clk);
            chk("rready", {63'd0, m_axil_rready}, 64'd1);
            @(posedge clk); #1;
            m_axil_rvalid = 1'b0; m_axil_rresp = 2'b00; m_axil_rdata = '0;
        end
        enable = 1'b1;
    endtask

    initial begin
        logic [63:0] pc;
        logic [1:0]  lo;
        int          fm;
        nreset = 1'b0; enable = 1'b0; i_read_instr = 1'b0; i_pc = '0; i_flush = 1'b0;
        m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, o_instr_valid}, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_arvalid", {63'd0, m_axil_arvalid}, 64'd0);
        chk("rst_rready", {63'd0, m_axil_rready}, 64'd0);
        chk("rst_araddr", m_axil_araddr, 64'd0);
        chk("rst_instr", {32'd0, o_instr}, 64'd0);
        @(posedge clk); #1 nreset = 1'b1; enable = 1'b1;

        // Upper word select, zero-wait latency
        mem[64'h1000] = 64'hAAAA_BBBB_1111_2222;
        do_fetch(64'h1004, 0, 0, 2'b00, 0);
        repeat (2) @(negedge clk);
        chk("latency_n3", 64'(last_valid_cyc - req_cyc), 64'd3);
        // Lower word, arready stall
        do_fetch(64'h1000, 3, 0, 2'b00, 0);
        // Error response
        do_fetch(64'h3008, 0, 1, 2'b10, 0);
        // Misaligned
        do_fetch(64'h1002, 0, 0, 2'b00, 0);
        // Flush while data pending, then new request
        do_fetch(64'h4000, 0, 2, 2'b00, 2);
        @(posedge clk);
        do_fetch(64'h4004, 0, 0, 2'b00, 0);
        // Flush while address pending, flush in error
        do_fetch(64'h5000, 2, 1, 2'b00, 1);
        do_fetch(64'h5001, 0, 0, 2'b00, 3);

        // Flush in IDLE blocks acceptance
        @(posedge clk); #1 i_read_instr = 1'b1; i_pc = 64'h6000; i_flush = 1'b1;
        @(posedge clk); #1 i_read_instr = 1'b0; i_flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_accept", {62'd0, o_busy, m_axil_arvalid}, 64'd0);
        // enable=0 blocks acceptance
        @(posedge clk); #1 i_read_instr = 1'b1; enable = 1'b0;
        @(posedge clk); #1 i_read_instr = 1'b0; enable = 1'b1;
        @(negedge clk);
        chk("disabled_no_accept", {62'd0, o_busy, m_axil_arvalid}, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            lo = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pc = (64'($urandom_range(0, 32'hFFFF)) << 2) | {62'd0, lo};
            fm = $urandom_range(0, 6);
            if (fm > 3) fm = 0;
            do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3),
                     2'($urandom_range(0, 3)), fm);
        end

        // Reset while the address phase is pending
        @(posedge clk); #1 i_read_instr = 1'b1; i_pc = 64'h7000;
        @(posedge clk); #1 i_read_instr = 1'b0;
        @(negedge clk);
        chk("pre_rst_arvalid", {63'd0, m_axil_arvalid}, 64'd1);
        #1 nreset = 1'b0;
        #1;
        chk("mid_rst_arvalid", {63'd0, m_axil_arvalid}, 64'd0);
        chk("mid_rst_busy", {63'd0, o_busy}, 64'd0);
        chk("mid_rst_araddr", m_axil_araddr, 64'd0);
        chk("mid_rst_instr_pc", o_instr_pc, 64'd0);
        chk("mid_rst_outs", {60'd0, o_instr_valid, o_fetch_err, m_axil_rready, |o_instr}, 64'd0);
        @(posedge clk); #1 nreset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", {62'd0, o_busy, m_axil_arvalid}, 64'd0);
        end
        do_fetch(64'h7004, 1, 1, 2'b00, 0);
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        chk("pulse_count", 64'(pulses), 64'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
